uart_receiver: RTL and testbench
================================

UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have parameter CLOCK_RATE, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115_200, serial bit rate in baud.
REQ-003 SHALL have port clk, input, 1, single system clock, rising-edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port enabled, input, 1, receiver enable; 0 forces IDLE and discards any partial frame.
REQ-006 SHALL have port in, input, 1, asynchronous serial line, idle high; driven by the transmitter's out port.
REQ-007 SHALL have port data, output, 8, last received byte.
REQ-008 SHALL have port done, output, 1, one-cycle pulse when data is updated with a good frame.
REQ-009 SHALL have port busy, output, 1, high from start-bit detect until return to IDLE.
REQ-010 SHALL have port err, output, 1, one-cycle pulse on a framing error, or on a parity error when parity is enabled.

Function
REQ-011 SHALL pass in through a 2-flop synchronizer reset to 1; all logic SHALL use the synchronized value.
REQ-012 SHALL generate an oversample tick every DIV = CLOCK_RATE/(BAUD_RATE*16) clocks, integer truncation, 27 at defaults; the divider counter SHALL free-run while enabled=1.
REQ-013 SHALL implement states IDLE, START, DATA, STOP, plus PARITY when parity is enabled.
REQ-014 IDLE->START SHALL occur on the first tick with synchronized in=0 and enabled=1; busy SHALL assert in the same cycle.
REQ-015 START SHALL resample at tick 8 (mid-bit): if 0, go to DATA with the tick count cleared; if 1, treat as a glitch and return to IDLE with no done and no err.
REQ-016 DATA SHALL sample every 16th tick at mid-bit, shifting LSB first; it SHALL leave after 8 bits.
REQ-017 STOP SHALL sample at mid-bit:
  - if 1: load data, pulse done for exactly 1 clk, and return to IDLE.
  - if 0: pulse err for 1 clk, leave data unchanged, and wait in STOP until synchronized in=1, then go to IDLE.
REQ-018 data SHALL hold its value until the next good frame.
REQ-019 done and err SHALL never be high in the same cycle.
REQ-020 Latency: done SHALL rise within 3 clk of the stop-bit mid-point sample.
REQ-021 enabled going 0 mid-frame SHALL return to IDLE on the next clk with busy=0, no done, no err, and data unchanged.
REQ-022 Back-to-back frames, with a start bit immediately after the stop-bit mid-point, SHALL be received without loss.

Reset
REQ-023 On rst_n=0 the block SHALL asynchronously clear to: state IDLE, data=8'h00, done=0, busy=0, err=0, all counters 0, synchronizer flops=1.
REQ-024 Reset release SHALL be synchronous to clk; the first start detect SHALL be possible on the first tick after release.

Configuration
REQ-025 Macro UART_RX_PARITY_EN defined: one even-parity bit SHALL follow the data bits and be sampled in state PARITY. A mismatch SHALL pulse err at the stop-bit sample in place of done, with data unchanged.
REQ-026 Macro UART_RX_PARITY_EN undefined: frame SHALL be 8N1, no PARITY state, and err SHALL report framing errors only.

Verification
REQ-027 Reset, then 8N1 frame 0x5A at defaults -> done pulse of 1 clk, data=8'h5A, err never high, busy=0 afterwards.
REQ-028 Frames 0xA5 then 0x3C back-to-back -> two done pulses, data=8'hA5 then 8'h3C.
REQ-029 Low glitch of 4 oversample ticks on an idle line -> no done, no err, busy returns to 0 within 9 ticks.
REQ-030 Frame 0xFF with stop bit forced 0 -> err pulse of 1 clk, data keeps its prior value, IDLE only after the line returns high.
REQ-031 rst_n low during bit 3 of frame 0x81, then frame 0x42 -> outputs cleared, only 0x42 reported.
REQ-032 With UART_RX_PARITY_EN: 0x07 with parity=1 -> done, data=8'h07; same byte with parity=0 -> err, no done.

Source files
------------

// File: rtl/uart_receiver.sv
// 16x-oversampling UART receiver, 8 data bits, LSB first, one stop bit.
// Define UART_RX_PARITY_EN to expect one even-parity bit between data and stop.
module uart_receiver #(
  parameter int CLOCK_RATE = 50_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enabled,
  input  logic       in,
  output logic [7:0] data,
  output logic       done,
  output logic       busy,
  output logic       err
);

  localparam int DIV = CLOCK_RATE / (BAUD_RATE * 16);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t        state_reg, state_next;
  logic          sync1_reg, sync2_reg;
  logic [DW-1:0] div_cnt_reg;
  logic [3:0]    tick_cnt_reg, tick_cnt_next;
  logic [2:0]    bit_cnt_reg, bit_cnt_next;
  logic [7:0]    shift_reg, shift_next;
  logic [7:0]    data_reg, data_next;
  logic          done_reg, done_next;
  logic          err_reg, err_next;
  logic          brk_reg, brk_next;
  logic          parity_ok;
  logic          tick;
  logic          rx;

`ifdef UART_RX_PARITY_EN
  logic par_reg, par_next;
  assign parity_ok = ~(^shift_reg ^ par_reg);
`else
  assign parity_ok = 1'b1;
`endif

  assign rx   = sync2_reg;
  assign tick = enabled && (div_cnt_reg == DIV_LAST);
  assign data = data_reg;
  assign done = done_reg;
  assign err  = err_reg;
  assign busy = (state_reg != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg    <= 1'b1;
      sync2_reg    <= 1'b1;
      div_cnt_reg  <= '0;
      state_reg    <= IDLE;
      tick_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      data_reg     <= '0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
      brk_reg      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_reg      <= 1'b0;
`endif
    end else begin
      sync1_reg <= in;
      sync2_reg <= sync1_reg;
      if (!enabled || div_cnt_reg == DIV_LAST) div_cnt_reg <= '0;
      else                                     div_cnt_reg <= div_cnt_reg + 1'b1;
      state_reg    <= state_next;
      tick_cnt_reg <= tick_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      shift_reg    <= shift_next;
      data_reg     <= data_next;
      done_reg     <= done_next;
      err_reg      <= err_next;
      brk_reg      <= brk_next;
`ifdef UART_RX_PARITY_EN
      par_reg      <= par_next;
`endif
    end
  end

  always_comb begin
    state_next    = state_reg;
    tick_cnt_next = tick_cnt_reg;
    bit_cnt_next  = bit_cnt_reg;
    shift_next    = shift_reg;
    data_next     = data_reg;
    done_next     = 1'b0;
    err_next      = 1'b0;
    brk_next      = brk_reg;
`ifdef UART_RX_PARITY_EN
    par_next      = par_reg;
`endif
    if (!enabled) begin
      state_next    = IDLE;
      tick_cnt_next = '0;
      bit_cnt_next  = '0;
      brk_next      = 1'b0;
    end else begin
      case (state_reg)
        IDLE: if (tick && !rx) begin
          state_next    = START;
          tick_cnt_next = '0;
          bit_cnt_next  = '0;
        end
        // Eighth tick after detect lands mid start bit; a high line there is a glitch.
        START: if (tick) begin
          if (tick_cnt_reg == 4'd7) begin
            tick_cnt_next = '0;
            state_next    = rx ? IDLE : DATA;
          end else begin
            tick_cnt_next = tick_cnt_reg + 4'd1;
          end
        end
        DATA: if (tick) begin
          if (tick_cnt_reg == 4'd15) begin
            tick_cnt_next = '0;
            shift_next    = {rx, shift_reg[7:1]};
            bit_cnt_next  = bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_next = PARITY;
`else
              state_next = STOP;
`endif
            end
          end else begin
            tick_cnt_next = tick_cnt_reg + 4'd1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: if (tick) begin
          if (tick_cnt_reg == 4'd15) begin
            tick_cnt_next = '0;
            par_next      = rx;
            state_next    = STOP;
          end else begin
            tick_cnt_next = tick_cnt_reg + 4'd1;
          end
        end
`endif
        // After a framing error, park here until the line is released high.
        STOP: if (brk_reg) begin
          if (rx) begin
            brk_next   = 1'b0;
            state_next = IDLE;
          end
        end else if (tick) begin
          if (tick_cnt_reg == 4'd15) begin
            tick_cnt_next = '0;
            if (rx) begin
              state_next = IDLE;
              if (parity_ok) begin
                data_next = shift_reg;
                done_next = 1'b1;
              end else begin
                err_next = 1'b1;
              end
            end else begin
              err_next = 1'b1;
              brk_next = 1'b1;
            end
          end else begin
            tick_cnt_next = tick_cnt_reg + 4'd1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at default rates; parity steps only when
// UART_RX_PARITY_EN is defined.
module tb_uart_receiver;

  localparam int DIV = 50_000_000 / (115_200 * 16);
  localparam int BIT = DIV * 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enabled;
  logic       line;
  logic [7:0] data;
  logic       done;
  logic       busy;
  logic       err;

  int n_assert = 0;
  int n_fail   = 0;
  int done_cnt, err_cnt, both_cnt, done_run, done_max, err_run, err_max, busy_seen;
  logic [7:0] got_q[$];

`ifdef UART_RX_PARITY_EN
  logic parity_flip = 1'b0;
`endif

  uart_receiver dut (
    .clk(clk), .rst_n(rst_n), .enabled(enabled), .in(line),
    .data(data), .done(done), .busy(busy), .err(err)
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      got_q.push_back(data);
    end
    if (err) err_cnt++;
    if (done && err) both_cnt++;
    done_run = done ? done_run + 1 : 0;
    err_run  = err ? err_run + 1 : 0;
    if (done_run > done_max) done_max = done_run;
    if (err_run > err_max) err_max = err_run;
    if (busy) busy_seen = 1;
  end

  task automatic clear_mon();
    done_cnt = 0; err_cnt = 0; both_cnt = 0;
    done_run = 0; done_max = 0; err_run = 0; err_max = 0; busy_seen = 0;
    got_q.delete();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b, input int len);
    line = b;
    repeat (len) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int stop_len);
    send_bit(1'b0, BIT);
    for (int i = 0; i < 8; i++) send_bit(b[i], BIT);
`ifdef UART_RX_PARITY_EN
    send_bit(^b ^ parity_flip, BIT);
`endif
    send_bit(stop_bit, stop_len);
  endtask

  function automatic logic [7:0] q_at(input int i);
    return (got_q.size() > i) ? got_q[i] : 8'hxx;
  endfunction

  initial begin
    clear_mon();
    rst_n = 1'b0; enabled = 1'b1; line = 1'b1;
    @(negedge clk);
    check("reset_data", data, 8'h00);
    check("reset_done", done, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_err",  err,  1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Single good frame
    clear_mon();
    send_frame(8'h5A, 1'b1, BIT);
    send_bit(1'b1, BIT);
    check("f5a_done_cnt", done_cnt, 1);
    check("f5a_done_width", done_max, 1);
    check("f5a_data", data, 8'h5A);
    check("f5a_err_cnt", err_cnt, 0);
    check("f5a_busy", busy, 1'b0);

    // Back-to-back: second start bit follows shortly after first stop mid-point
    clear_mon();
    send_frame(8'hA5, 1'b1, (BIT * 3) / 4);
    send_frame(8'h3C, 1'b1, BIT);
    send_bit(1'b1, BIT);
    check("b2b_done_cnt", done_cnt, 2);
    check("b2b_first", q_at(0), 8'hA5);
    check("b2b_second", q_at(1), 8'h3C);
    check("b2b_err_cnt", err_cnt, 0);

    // Start-bit glitch of 4 ticks
    clear_mon();
    send_bit(1'b0, 4 * DIV);
    send_bit(1'b1, 9 * DIV);
    check("glitch_seen", busy_seen, 1);
    check("glitch_busy", busy, 1'b0);
    check("glitch_done", done_cnt, 0);
    check("glitch_err", err_cnt, 0);
    send_bit(1'b1, BIT);

    // Framing error: stop bit low, line held low afterwards
    clear_mon();
    send_frame(8'hFF, 1'b0, BIT);
    send_bit(1'b0, BIT);
    check("ferr_err_cnt", err_cnt, 1);
    check("ferr_err_width", err_max, 1);
    check("ferr_done_cnt", done_cnt, 0);
    check("ferr_data", data, 8'h3C);
    check("ferr_busy_low_line", busy, 1'b1);
    send_bit(1'b1, 6);
    check("ferr_busy_released", busy, 1'b0);
    send_bit(1'b1, BIT);

    // Reset during bit 3 of 0x81
    clear_mon();
    send_bit(1'b0, BIT);
    send_bit(1'b1, BIT);
    send_bit(1'b0, BIT);
    send_bit(1'b0, BIT);
    send_bit(1'b0, BIT / 2);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_data", data, 8'h00);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_done", done, 1'b0);
    check("rst_mid_err", err, 1'b0);
    line = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    send_bit(1'b1, BIT);
    send_frame(8'h42, 1'b1, BIT);
    send_bit(1'b1, BIT);
    check("rst_mid_done_cnt", done_cnt, 1);
    check("rst_mid_frame", q_at(0), 8'h42);
    check("rst_mid_data_after", data, 8'h42);

    // Enable dropped mid-frame
    clear_mon();
    send_bit(1'b0, BIT);
    for (int i = 0; i < 4; i++) send_bit(i[0], BIT);
    check("en_busy_before", busy, 1'b1);
    enabled = 1'b0;
    @(negedge clk);
    check("en_busy_after", busy, 1'b0);
    line = 1'b1;
    repeat (BIT) @(negedge clk);
    enabled = 1'b1;
    repeat (BIT) @(negedge clk);
    check("en_done_cnt", done_cnt, 0);
    check("en_err_cnt", err_cnt, 0);
    check("en_data", data, 8'h42);

`ifdef UART_RX_PARITY_EN
    clear_mon();
    parity_flip = 1'b0;
    send_frame(8'h07, 1'b1, BIT);
    send_bit(1'b1, BIT);
    check("par_good_done", done_cnt, 1);
    check("par_good_err", err_cnt, 0);
    check("par_good_data", data, 8'h07);
    clear_mon();
    parity_flip = 1'b1;
    send_frame(8'h07, 1'b1, BIT);
    send_bit(1'b1, BIT);
    parity_flip = 1'b0;
    check("par_bad_done", done_cnt, 0);
    check("par_bad_err", err_cnt, 1);
    check("par_bad_data", data, 8'h07);
`endif

    check("done_err_overlap", both_cnt, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
